// File: rtl/ser_tx4_if.sv
// Handshake and serial-link bundle for ser_tx4.
// The source drives start/d/en; the transmitter drives ready/sout/sout_valid/done.
interface ser_tx4_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] d;
    logic             en;
    logic             ready;
    logic             sout;
    logic             sout_valid;
    logic             done;

    modport master (
        output start, d, en,
        input  ready, sout, sout_valid, done
    );

    modport slave (
        input  start, d, en,
        output ready, sout, sout_valid, done
    );
endinterface

// File: rtl/ser_tx4.sv
// ser_tx4: parallel-in / serial-out transmitter, MSB first, one bit per enabled clock.
// Optional even-parity bit after the data bits when SER_TX_PARITY_EN is defined.
// Synchronous active-high reset; sout/sout_valid/done are registered.
module ser_tx4 #(
    parameter int unsigned WIDTH = 4
) (
    input logic       clk,
    input logic       reset,
    ser_tx4_if.slave  bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

`ifdef SER_TX_PARITY_EN
    typedef enum logic [1:0] {StIdle = 2'd0, StShift = 2'd1, StParity = 2'd2} state_e;
`else
    typedef enum logic [1:0] {StIdle = 2'd0, StShift = 2'd1} state_e;
`endif

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              sout_q, sout_d;
    logic              sout_valid_q, sout_valid_d;
    logic              done_q, done_d;
`ifdef SER_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    // Next-state: accept a word in idle, walk the bit counter on enabled edges.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef SER_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            StIdle: begin
                // en is deliberately not required for acceptance
                if (bus.start) begin
                    shreg_d = bus.d;
                    cnt_d   = '0;
                    state_d = StShift;
`ifdef SER_TX_PARITY_EN
                    par_d   = ^bus.d;
`endif
                end
            end
            StShift: begin
                if (bus.en) begin
                    if (cnt_q == LastCnt) begin
`ifdef SER_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StIdle;
                        done_d  = 1'b1;
`endif
                    end else begin
                        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                        cnt_d   = cnt_q + CntW'(1);
                    end
                end
            end
`ifdef SER_TX_PARITY_EN
            StParity: begin
                if (bus.en) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Registered serial outputs follow the next state so they line up with it.
    always_comb begin
        sout_valid_d = (state_d != StIdle);
        sout_d       = 1'b0;
        if (state_d == StShift) begin
            sout_d = shreg_d[WIDTH-1];
        end
`ifdef SER_TX_PARITY_EN
        if (state_d == StParity) begin
            sout_d = par_d;
        end
`endif
    end

    // State and output registers; reset wins over start and en.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            shreg_q      <= '0;
            cnt_q        <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            done_q       <= 1'b0;
`ifdef SER_TX_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            done_q       <= done_d;
`ifdef SER_TX_PARITY_EN
            par_q        <= par_d;
`endif
        end
    end

    assign bus.ready      = (state_q == StIdle) && !reset;
    assign bus.sout       = sout_q;
    assign bus.sout_valid = sout_valid_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_ser_tx4.sv
// Scoreboard bench for ser_tx4: accepted words are expanded into expected bit frames,
// a negedge monitor pops bits as the link consumes them (sout_valid && en).
module tb_ser_tx4;
    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic reset;

    ser_tx4_if #(.WIDTH(W)) bus ();

    ser_tx4 #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

    // Reference: queue of expected link bits, with a marker on each frame's last bit.
    bit exp_bits[$];
    bit exp_last[$];
    bit busy = 1'b0;
    bit done_exp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic push_frame(input logic [W-1:0] word);
        for (int i = W - 1; i >= 0; i--) begin
            exp_bits.push_back(word[i]);
            exp_last.push_back(1'b0);
        end
`ifdef SER_TX_PARITY_EN
        begin
            int ones = 0;
            for (int i = 0; i < W; i++) ones += int'(word[i]);
            exp_bits.push_back(ones % 2 == 1);
            exp_last.push_back(1'b0);
        end
`endif
        exp_last[exp_last.size() - 1] = 1'b1;
    endtask

    // Monitor: compare outputs mid-cycle, then advance the model for the coming edge.
    always @(negedge clk) begin
        if (checking) begin
            bit nb;
            bit nd;
            check("sout_valid", {31'b0, bus.sout_valid}, {31'b0, busy});
            check("ready", {31'b0, bus.ready}, {31'b0, (!reset && !busy)});
            check("done", {31'b0, bus.done}, {31'b0, done_exp});
            if (busy) begin
                if (exp_bits.size() == 0) begin
                    check("queue_underrun", 32'd1, 32'd0);
                end else begin
                    check("sout_bit", {31'b0, bus.sout}, {31'b0, exp_bits[0]});
                end
            end else begin
                check("sout_idle", {31'b0, bus.sout}, 32'd0);
            end

            nb = busy;
            nd = 1'b0;
            if (reset) begin
                exp_bits.delete();
                exp_last.delete();
                nb = 1'b0;
            end else if (busy && bus.en) begin
                if (exp_bits.size() != 0) begin
                    bit last;
                    void'(exp_bits.pop_front());
                    last = exp_last.pop_front();
                    if (last) begin
                        nb = 1'b0;
                        nd = 1'b1;
                    end
                end
            end else if (!busy && bus.start) begin
                push_frame(bus.d);
                nb = 1'b1;
            end
            busy     = nb;
            done_exp = nd;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.d     = '0;
        bus.en    = 1'b0;
        step();
        step();
        reset    = 1'b0;
        checking = 1'b1;
        repeat (2) step();

        // 0xA with en held high
        bus.en = 1'b1; bus.start = 1'b1; bus.d = 4'hA;
        step();
        bus.start = 1'b0; bus.d = 4'h5;
        repeat (7) step();

        // 0xB with en toggling after the accept edge
        bus.start = 1'b1; bus.d = 4'hB;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            bus.en = (i % 2 == 0) ? 1'b1 : 1'b0;
            step();
        end
        bus.en = 1'b1;
        repeat (2) step();

        // start held: 0x3 then 0xC back to back
        bus.start = 1'b1; bus.d = 4'h3;
        step();
        bus.d = 4'hC;
        repeat (6) step();
        bus.start = 1'b0;
        repeat (8) step();

        // reset during bit 2 of 0xF, then a normal start
        bus.start = 1'b1; bus.d = 4'hF;
        step();
        bus.start = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        step();
        reset = 1'b0; bus.start = 1'b1; bus.d = 4'h9;
        step();
        bus.start = 1'b0;
        repeat (7) step();

        // start pulsed mid-frame with a different word
        bus.start = 1'b1; bus.d = 4'h6;
        step();
        bus.start = 1'b0;
        step();
        bus.start = 1'b1; bus.d = 4'h9;
        repeat (2) step();
        bus.start = 1'b0;
        repeat (7) step();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bus.start = ($urandom_range(0, 2) == 0);
            bus.d     = W'($urandom);
            bus.en    = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 99) == 0);
            step();
        end

        // Drain any frame in flight
        reset = 1'b0; bus.start = 1'b0; bus.en = 1'b1;
        repeat (20) step();
        check("drained", exp_bits.size(), 32'd0);
        check("idle_end", {31'b0, bus.ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ser_tx4.md
# ser_tx4

Parallel-in/serial-out transmitter that feeds the serial input of the 4-bit shift-register receiver. It accepts a WIDTH-bit word on a valid/ready handshake and shifts it out MSB-first, one bit per enabled clock. It marks each bit with a qualifier and pulses a completion flag. It sits between the parallel data source and the serial link, upstream of the receiver's `sin`.

## Interface
- `WIDTH`, 4: word width in bits; legal values 2–16.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  request to transmit `d`; accepted on a rising edge where `start && ready`.
- `d`  input  WIDTH  word to transmit; sampled only on the accept edge.
- `en`  input  1  bit-rate enable; the serial stream advances only on edges with `en=1`.
- `ready`  output  1  high in IDLE and low while `reset=1`; combinational from state.
- `sout`  output  1  serial data bit; connects to the receiver's `sin`.
- `sout_valid`  output  1  high while `sout` carries a frame bit.
- `done`  output  1  one-cycle pulse after the last frame bit has been held.

## Operation
States:
- **IDLE**
  - `ready=1`, `sout=0`, `sout_valid=0`.
  - On `start && ready`: `shreg <= d`, `cnt <= 0`, go to SHIFT. `en` is ignored for acceptance.
  - `start` while not ready is ignored. No queuing.
- **SHIFT**
  - `sout = shreg[WIDTH-1]`, `sout_valid=1`.
  - On an edge with `en=1` and `cnt < WIDTH-1`: shift `shreg` left with a 0 fill, `cnt <= cnt+1`.
  - On an edge with `en=1` and `cnt == WIDTH-1`: go to PARITY if it is compiled in, else go to IDLE with `done <= 1`.
  - `en=0`: hold all state; `sout` is stable.
- **PARITY** (only with the macro, see Configuration)
  - `sout = par`, `sout_valid=1`.
  - On an edge with `en=1`: go to IDLE with `done <= 1`.

Datapath and flags:
- Bit counter width is `$clog2(WIDTH)`; it never wraps past `WIDTH-1`.
- `done` is registered, high for exactly one cycle, and cleared on every other edge.
- `d` changing after the accept edge has no effect on the frame in flight.
- Reset values, from the edge after `reset=1` is sampled:
  - state = IDLE
  - `shreg`, `cnt`, `par` = 0
  - `sout`, `sout_valid`, `done` = 0
  - `ready` = 1 once `reset` deasserts
- Reset mid-frame aborts the frame. No `done` pulse is produced, and the next cycle is IDLE with outputs at reset values.
- Reset has priority over `start` and `en` on the same edge.

## Timing
- Accept edge T0 → `sout_valid=1` and `sout=d[WIDTH-1]` during cycle T0+1.
- With `en` held at 1:
  - bit k (MSB = 0) is driven during cycle T0+1+k;
  - the last data bit is driven during T0+WIDTH;
  - without parity, `done=1` and `ready=1` during T0+WIDTH+1;
  - with parity, the parity bit is driven during T0+WIDTH+1, and `done`/`ready` are high during T0+WIDTH+2.
- Each `en=0` cycle inside a frame extends the frame by one cycle; the bit on `sout` is repeated.
- Back-to-back frames: `start` held high is accepted in the `done` cycle. Minimum gap between frames is one cycle with `sout_valid=0`.
- The receiver samples `sin` on edges where `sout_valid && en`.

## Configuration
- `SER_TX_PARITY_EN`
  - Defined: PARITY state is present and an even-parity bit is appended after the data bits. `par` is the XOR of all bits of `d`, computed at the accept edge. A frame is WIDTH+1 bits.
  - Undefined: PARITY state, `par` register and parity logic are absent. A frame is WIDTH bits.
  - The interface is identical in both builds.

## Test plan
- Reset, then release → `ready=1`, `sout=0`, `sout_valid=0`, `done=0` from the first post-reset cycle.
- WIDTH=4, `en=1`, `d=4'hA`, `start` for 1 cycle → `sout` reads 1,0,1,0 on T0+1..T0+4 with `sout_valid=1`; `done=1` and `ready=1` at T0+5. With parity: an extra bit 0 at T0+5 and `done` at T0+6.
- `d=4'hB`, `en` toggling 1,0 → each bit held for 2 cycles; `done` at T0+9 without parity. With parity, the parity bit is 1.
- `start` held high with `d=4'h3` then `4'hC` → two frames separated by exactly one idle cycle; bits read 0,0,1,1 then 1,1,0,0.
- `reset` asserted during bit 2 of `d=4'hF` → IDLE on the next cycle, no `done` pulse; `start` on the next cycle after reset release is accepted normally.
- `start` pulsed mid-frame with a different `d` → ignored; the in-flight frame bits are unchanged.
